// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer family.
package mux_pkg;

  localparam int MUX_NUM_CH_DEF = 4;
  localparam int MUX_DATA_W_DEF = 16;

  // Channel-ID width for a given channel count (at least one bit).
  function automatic int mux_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH = MUX_NUM_CH_DEF,
  localparam int SEL_W  = mux_sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_id,
  output logic              any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      // ptr is always below NUM_CH, so one subtraction wraps the search index.
      idx = int'(ptr) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (en && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = SEL_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output.
// Optional RR_STREAM_MUX_FORCE_EN adds force_en/force_sel to pin arbitration to one channel.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int NUM_CH = MUX_NUM_CH_DEF,
  parameter  int DATA_W = MUX_DATA_W_DEF,
  localparam int SEL_W  = mux_sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef RR_STREAM_MUX_FORCE_EN
  ,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel
`endif
);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              load;
  logic              arb_en;
  logic              any_grant;
  logic              ptr_upd;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_id;
  logic [DATA_W-1:0] in_word [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_word
    assign in_word[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  // Register can take a word when empty or being drained this cycle.
  assign load   = !out_valid_q || out_ready;
  assign arb_en = load && !reset;

`ifdef RR_STREAM_MUX_FORCE_EN
  logic [NUM_CH-1:0] force_mask;

  always_comb begin
    force_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      force_mask[i] = (int'(force_sel) == i);
    end
  end

  assign req     = force_en ? (in_valid & force_mask) : in_valid;
  assign ptr_upd = !force_en;
`else
  assign req     = in_valid;
  assign ptr_upd = 1'b1;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  assign in_ready = grant;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any_grant) begin
        out_data_d  = in_word[grant_id];
        out_sel_d   = grant_id;
        out_valid_d = 1'b1;
        if (ptr_upd) begin
          ptr_d = (grant_id == SEL_W'(NUM_CH-1)) ? '0 : grant_id + SEL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed phases then randomized traffic vs a reference model.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_valid;
  logic            out_ready;
  logic            force_en;
  logic [1:0]      force_sel;

  logic [23:0]     in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic [7:0]      out_data3;
  logic [1:0]      out_sel3;
  logic            out_valid3;
  logic            out_ready3;
  logic            force_en3;
  logic [1:0]      force_sel3;

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_STREAM_MUX_FORCE_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef RR_STREAM_MUX_FORCE_EN
    ,
    .force_en  (force_en3),
    .force_sel (force_sel3)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus variables
  logic [N-1:0]  v_valid;
  logic [DW-1:0] v_data [N];
  logic          v_oready;
  logic          v_reset;
  logic          fe_v;
  int            fs_v;

  // Reference model state
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            last_g;
  logic [N-1:0]  obs_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Eligible channel with the smallest forward distance from the pointer wins.
  function automatic int pick(input logic [N-1:0] v, input int p, input logic fe, input int fs);
    int best = -1;
    int best_d = N;
    for (int c = 0; c < N; c++) begin
      if (v[c] && (!fe || c == fs)) begin
        int d = (c - p + N) % N;
        if (d < best_d) begin
          best   = c;
          best_d = d;
        end
      end
    end
    return best;
  endfunction

  task automatic do_cycle();
    int g;
    logic [N-1:0] exp_ready;
    reset     = v_reset;
    in_valid  = v_valid;
    out_ready = v_oready;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = v_data[i];
    force_en  = fe_v;
    force_sel = fs_v[1:0];
    #1;
    g = -1;
    if (!v_reset && (!m_valid || v_oready)) g = pick(v_valid, m_ptr, fe_v, fs_v);
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    obs_ready = in_ready;
    check("in_ready", in_ready, exp_ready);
    last_g = g;
    @(posedge clk);
    if (v_reset) begin
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
    end else if (!m_valid || v_oready) begin
      if (g >= 0) begin
        m_data  = v_data[g];
        m_sel   = g;
        m_valid = 1'b1;
        if (!fe_v) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    $display("cyc t=%0t rst=%0b vld=%b ordy=%0b rdy=%b -> out_v=%0b sel=%0d data=%h",
             $time, v_reset, v_valid, v_oready, obs_ready, out_valid, out_sel, out_data);
    check("out_valid", out_valid, m_valid);
    check("out_sel", out_sel, m_sel);
    check("out_data", out_data, m_data);
  endtask

  initial begin
`ifdef RR_STREAM_MUX_FORCE_EN
    fe_v = 1'b0;
`else
    fe_v = 1'b0;
`endif
    fs_v = 0;
    force_en3 = 1'b0; force_sel3 = 2'd0;
    in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = {8'hC2, 8'hC1, 8'hC0};
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0; last_g = -1;
    v_oready = 1'b1;
    v_valid  = '1;
    for (int i = 0; i < N; i++) v_data[i] = DW'(16'hA000 + i);

    // Reset for two cycles with every channel requesting
    v_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_cycle();
      check("rst_ready", obs_ready, 0);
      check("rst_valid", out_valid, 0);
    end

    // Full load: 0,1,2,3,0 one word per cycle; N=3 instance wraps 2 -> 0
    v_reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      do_cycle();
      if (j == 0) check("first_grant", obs_ready, 4'b0001);
      check("full_sel", out_sel, j % 4);
      check("full_data", out_data, 16'hA000 + (j % 4));
      check("full_valid", out_valid, 1);
      check("n3_sel", out_sel3, j % 3);
      check("n3_data", out_data3, 8'hC0 + (j % 3));
    end

    // Backpressure holding 16'h1234, then release with no bubble
    v_data[1] = 16'h1234;
    do_cycle();
    check("bp_load", out_data, 16'h1234);
    v_oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      check("bp_hold_data", out_data, 16'h1234);
      check("bp_hold_ready", obs_ready, 0);
    end
    v_oready = 1'b1;
    do_cycle();
    check("bp_release_ready", obs_ready, 4'b0100);
    check("bp_nobubble_valid", out_valid, 1);
    check("bp_nobubble_sel", out_sel, 2);

    // Sparse: move ptr to 2, then channels 1 and 3 -> 3 first, then 1
    v_valid = 4'b0010;
    do_cycle();
    v_valid = 4'b1010;
    do_cycle();
    check("sparse_first", out_sel, 3);
    v_valid = 4'b0010;
    do_cycle();
    check("sparse_wrap", out_sel, 1);

`ifdef RR_STREAM_MUX_FORCE_EN
    // Override to channel 2; ptr (now 2) must not move while forced
    v_valid = '1;
    fe_v = 1'b1; fs_v = 2;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      check("force_ready", obs_ready, 4'b0100);
      check("force_sel", out_sel, 2);
    end
    fe_v = 1'b0;
    do_cycle();
    check("force_resume", out_sel, 2);
    do_cycle();
    check("force_resume_next", out_sel, 3);
`endif

    // Reset while a word is stalled
    v_valid = '1;
    v_oready = 1'b0;
    do_cycle();
    check("mid_stall_valid", out_valid, 1);
    v_reset = 1'b1;
    do_cycle();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", obs_ready, 0);
    v_reset = 1'b0;
    v_oready = 1'b1;
    do_cycle();
    check("mid_rst_restart", out_sel, 0);

    // Randomized traffic; producers hold valid/data until accepted
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (!(v_valid[c] && last_g != c)) begin
          v_valid[c] = ($urandom_range(0, 99) < 60);
          v_data[c]  = DW'($urandom);
        end
      end
      v_oready = ($urandom_range(0, 99) < 70);
      v_reset  = ($urandom_range(0, 99) < 3);
`ifdef RR_STREAM_MUX_FORCE_EN
      fe_v = ($urandom_range(0, 99) < 15);
      fs_v = $urandom_range(0, N-1);
`endif
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
